// File: rtl/tof_mem_write_arbiter_pkg.sv
// Shared constants and types for the ToF sensor BRAM write arbiter.
package tof_mem_pkg;

    localparam int N_SENSORS    = 8;
    localparam int DATA_W       = 16;
    localparam int SLOT_W       = 4;
    localparam int WRITE_CYCLES = 2;

    localparam int IDX_W  = $clog2(N_SENSORS);
    localparam int ADDR_W = IDX_W + SLOT_W;
    localparam int CNT_W  = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WRITE = 2'd1,
        ARB_ACK   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tof_mem_write_arbiter_rr_priority_pick.sv
// Circular priority encoder: returns the first set request at or after ptr.
module rr_priority_pick
    import tof_mem_pkg::*;
(
    input  logic [N_SENSORS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit to ptr is kept last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_SENSORS - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tof_mem_write_arbiter.sv
// Shares one BRAM write port between N_SENSORS ToF channels, round-robin,
// writing each channel's samples into its own circular region.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | waiting for a pending request; grants on the same cycle
// ARB_WRITE | wea held high for WRITE_CYCLES cycles, address/data stable
// ARB_ACK   | one-cycle tof_ack pulse, advance slot and round-robin ptr
module tof_mem_write_arbiter
    import tof_mem_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_SENSORS-1:0]          ToF_dr,
    input  logic [N_SENSORS*DATA_W-1:0]   tof_data,
    output logic                          wea,
    output logic [ADDR_W-1:0]             addra,
    output logic [DATA_W-1:0]             dina,
    output logic [IDX_W-1:0]              ToF_Index,
    output logic [N_SENSORS-1:0]          tof_ack,
    output logic [N_SENSORS-1:0]          overrun,
    output logic                          busy
);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [N_SENSORS-1:0]   dr_q;
    logic [N_SENSORS-1:0]   rise;
    logic [N_SENSORS-1:0]   pending;
    logic [N_SENSORS-1:0]   clr;
    logic [IDX_W-1:0]       rr_ptr;
    logic [SLOT_W-1:0]      wr_ptr [N_SENSORS];
    logic [CNT_W-1:0]       cnt;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   grant;

    rr_priority_pick u_pick (
        .req   (pending),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign rise  = ToF_dr & ~dr_q;
    assign grant = (state == ARB_IDLE) && pick_valid;

    // One-hot clear of the channel being granted this cycle.
    always_comb begin
        clr = '0;
        if (grant) begin
            clr[pick_idx] = 1'b1;
        end
    end

    // Data-ready history; also tracked in reset so a held level is not a request.
    always_ff @(posedge clk) begin
        dr_q <= ToF_dr;
    end

    // Request queue and sticky overrun; a new rise beats the grant clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            overrun <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            overrun <= overrun | (rise & pending & ~clr);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_valid) state_nxt = ARB_WRITE;
            ARB_WRITE: if (cnt == '0)  state_nxt = ARB_ACK;
            ARB_ACK:   state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // FSM outputs, decoded from state and the held grant index.
    always_comb begin
        wea     = (state == ARB_WRITE);
        busy    = (state != ARB_IDLE);
        tof_ack = '0;
        if (state == ARB_ACK) begin
            tof_ack[ToF_Index] = 1'b1;
        end
    end

    // Grant capture, write-length down-counter, and slot/pointer advance on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            addra     <= '0;
            dina      <= '0;
            ToF_Index <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                wr_ptr[i] <= '0;
            end
        end else begin
            if (grant) begin
                ToF_Index <= pick_idx;
                dina      <= tof_data[int'(pick_idx)*DATA_W +: DATA_W];
                addra     <= {pick_idx, wr_ptr[pick_idx]};
                cnt       <= CNT_W'(WRITE_CYCLES - 1);
            end
            if (state == ARB_WRITE && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == ARB_ACK) begin
                wr_ptr[ToF_Index] <= wr_ptr[ToF_Index] + SLOT_W'(1);
                rr_ptr            <= ToF_Index + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tof_mem_write_arbiter.sv
// Bench for tof_mem_write_arbiter: cycle vector table, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_tof_mem_write_arbiter;
    import tof_mem_pkg::*;

    localparam int N = N_SENSORS;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          ToF_dr;
    logic [N*DATA_W-1:0]   tof_data;
    logic                  wea;
    logic [ADDR_W-1:0]     addra;
    logic [DATA_W-1:0]     dina;
    logic [IDX_W-1:0]      ToF_Index;
    logic [N-1:0]          tof_ack;
    logic [N-1:0]          overrun;
    logic                  busy;

    tof_mem_write_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .ToF_dr    (ToF_dr),
        .tof_data  (tof_data),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .ToF_Index (ToF_Index),
        .tof_ack   (tof_ack),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a request set, per-channel slot counts,
    // and the current write transaction expressed as a phase number.
    bit               m_valid = 0;
    logic [N-1:0]     m_drq, m_pend, m_ovr;
    int               m_wr [N];
    int               m_rr, m_phase, m_sel, m_addr;
    logic [DATA_W-1:0] m_data;

    task automatic model_step();
        logic [N-1:0] rise;
        logic [N-1:0] clr;
        bit found;
        if (reset) begin
            m_valid = 1; m_drq = ToF_dr; m_pend = '0; m_ovr = '0;
            for (int i = 0; i < N; i++) m_wr[i] = 0;
            m_rr = 0; m_phase = 0; m_sel = 0; m_addr = 0; m_data = '0;
            return;
        end
        if (!m_valid) return;
        rise  = ToF_dr & ~m_drq;
        m_drq = ToF_dr;
        clr   = '0;
        if (m_phase == 0) begin
            if (m_pend != '0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && m_pend[(m_rr + k) % N]) begin
                        m_sel = (m_rr + k) % N;
                        found = 1;
                    end
                end
                m_addr = m_sel * (1 << SLOT_W) + m_wr[m_sel];
                m_data = tof_data[m_sel*DATA_W +: DATA_W];
                clr[m_sel] = 1'b1;
                m_phase = 1;
            end
        end else if (m_phase <= WRITE_CYCLES) begin
            m_phase++;
        end else begin
            m_wr[m_sel] = (m_wr[m_sel] + 1) % (1 << SLOT_W);
            m_rr = (m_sel + 1) % N;
            m_phase = 0;
        end
        m_ovr  = m_ovr | (rise & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | rise;
    endtask

    task automatic model_check();
        if (!m_valid) return;
        chk("m_wea", wea, (m_phase >= 1 && m_phase <= WRITE_CYCLES));
        chk("m_busy", busy, (m_phase != 0));
        chk("m_ack", tof_ack, (m_phase == WRITE_CYCLES + 1) ? (1 << m_sel) : 0);
        chk("m_addra", addra, m_addr);
        chk("m_dina", dina, m_data);
        chk("m_index", ToF_Index, m_sel);
        chk("m_overrun", overrun, m_ovr);
    endtask

    int  grants[$];
    int  ack_cnt [N];
    bit  prev_wea = 0;

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_check();
        if (wea === 1'b1 && !prev_wea) grants.push_back(int'(ToF_Index));
        prev_wea = (wea === 1'b1);
        for (int i = 0; i < N; i++) if (tof_ack[i] === 1'b1) ack_cnt[i]++;
    endtask

    task automatic clear_acks();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ToF_dr = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    typedef struct {
        logic              rst;
        logic [N-1:0]      dr;
        logic              wea;
        logic [ADDR_W-1:0] addra;
        logic [DATA_W-1:0] dina;
        logic [IDX_W-1:0]  idx;
        logic [N-1:0]      ack;
        logic              busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [N-1:0] d, input logic w,
                                input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] di,
                                input logic [IDX_W-1:0] ix, input logic [N-1:0] ak,
                                input logic b);
        vec_t v;
        v.rst = r; v.dr = d; v.wea = w; v.addra = a; v.dina = di;
        v.idx = ix; v.ack = ak; v.busy = b;
        return v;
    endfunction

    vec_t tbl [25];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        logic [N-1:0] nd;

        // Inputs apply during the vector's cycle; expectations are that cycle's outputs.
        tbl[0]  = mk(0, 8'h00, 0, 7'h00, 16'h0000, 0, 8'h00, 0);
        tbl[1]  = mk(0, 8'h08, 0, 7'h00, 16'h0000, 0, 8'h00, 0);
        tbl[2]  = mk(0, 8'h08, 0, 7'h00, 16'h0000, 0, 8'h00, 0);
        tbl[3]  = mk(0, 8'h08, 1, 7'h30, 16'hA5A5, 3, 8'h00, 1);
        tbl[4]  = mk(0, 8'h00, 1, 7'h30, 16'hA5A5, 3, 8'h00, 1);
        tbl[5]  = mk(0, 8'h00, 0, 7'h30, 16'hA5A5, 3, 8'h08, 1);
        tbl[6]  = mk(0, 8'h00, 0, 7'h30, 16'hA5A5, 3, 8'h00, 0);
        tbl[7]  = mk(0, 8'h08, 0, 7'h30, 16'hA5A5, 3, 8'h00, 0);
        tbl[8]  = mk(0, 8'h08, 0, 7'h30, 16'hA5A5, 3, 8'h00, 0);
        tbl[9]  = mk(0, 8'h00, 1, 7'h31, 16'hA5A5, 3, 8'h00, 1);
        tbl[10] = mk(0, 8'h00, 1, 7'h31, 16'hA5A5, 3, 8'h00, 1);
        tbl[11] = mk(0, 8'h00, 0, 7'h31, 16'hA5A5, 3, 8'h08, 1);
        tbl[12] = mk(0, 8'h00, 0, 7'h31, 16'hA5A5, 3, 8'h00, 0);
        tbl[13] = mk(1, 8'h00, 0, 7'h31, 16'hA5A5, 3, 8'h00, 0);
        tbl[14] = mk(0, 8'h00, 0, 7'h00, 16'h0000, 0, 8'h00, 0);
        tbl[15] = mk(0, 8'h81, 0, 7'h00, 16'h0000, 0, 8'h00, 0);
        tbl[16] = mk(0, 8'h81, 0, 7'h00, 16'h0000, 0, 8'h00, 0);
        tbl[17] = mk(0, 8'h81, 1, 7'h00, 16'h1111, 0, 8'h00, 1);
        tbl[18] = mk(0, 8'h81, 1, 7'h00, 16'h1111, 0, 8'h00, 1);
        tbl[19] = mk(0, 8'h81, 0, 7'h00, 16'h1111, 0, 8'h01, 1);
        tbl[20] = mk(0, 8'h81, 0, 7'h00, 16'h1111, 0, 8'h00, 0);
        tbl[21] = mk(0, 8'h81, 1, 7'h70, 16'h7777, 7, 8'h00, 1);
        tbl[22] = mk(0, 8'h81, 1, 7'h70, 16'h7777, 7, 8'h00, 1);
        tbl[23] = mk(0, 8'h81, 0, 7'h70, 16'h7777, 7, 8'h80, 1);
        tbl[24] = mk(0, 8'h00, 0, 7'h70, 16'h7777, 7, 8'h00, 0);

        reset    = 1'b1;
        ToF_dr   = '0;
        tof_data = '0;
        tof_data[3*DATA_W +: DATA_W] = 16'hA5A5;
        tof_data[0*DATA_W +: DATA_W] = 16'h1111;
        tof_data[7*DATA_W +: DATA_W] = 16'h7777;
        repeat (3) tick();

        chk("rst_wea", wea, 0);
        chk("rst_addra", addra, 0);
        chk("rst_dina", dina, 0);
        chk("rst_index", ToF_Index, 0);
        chk("rst_ack", tof_ack, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        for (int k = 0; k < 25; k++) begin
            chk($sformatf("v%0d_wea", k), wea, tbl[k].wea);
            chk($sformatf("v%0d_addra", k), addra, tbl[k].addra);
            chk($sformatf("v%0d_dina", k), dina, tbl[k].dina);
            chk($sformatf("v%0d_index", k), ToF_Index, tbl[k].idx);
            chk($sformatf("v%0d_ack", k), tof_ack, tbl[k].ack);
            chk($sformatf("v%0d_busy", k), busy, tbl[k].busy);
            reset  = tbl[k].rst;
            ToF_dr = tbl[k].dr;
            tick();
        end

        // Round-robin fairness: ch1 and ch2 re-request right after each ack.
        do_reset();
        grants.delete();
        ToF_dr = 8'h06;
        for (int cyc = 0; cyc < 200 && grants.size() < 6; cyc++) begin
            tick();
            ToF_dr[1] = !(tof_ack[1] === 1'b1);
            ToF_dr[2] = !(tof_ack[2] === 1'b1);
        end
        chk("rr_grant_count", (grants.size() >= 6), 1);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? 1 : 2);
        ToF_dr = '0;
        repeat (12) tick();

        // Slot wrap-around on ch5: 17 writes land on slots 0..15 then 0.
        do_reset();
        for (int r = 0; r < 17; r++) begin
            tof_data[5*DATA_W +: DATA_W] = 16'h5500 + 16'(r);
            ToF_dr[5] = 1'b1;
            tick();
            ToF_dr[5] = 1'b0;
            got = 0;
            for (int t = 0; t < 20 && !got; t++) begin
                tick();
                if (tof_ack[5] === 1'b1) got = 1;
            end
            chk($sformatf("wrap%0d_ack_seen", r), got, 1);
            if (got) begin
                chk($sformatf("wrap%0d_addra", r), addra, 5 * 16 + (r % 16));
                chk($sformatf("wrap%0d_dina", r), dina, 16'h5500 + 16'(r));
            end
            tick();
        end
        chk("wrap_overrun", overrun, 0);

        // Overrun: ch2 rises twice while ch0 is being written.
        do_reset();
        clear_acks();
        ToF_dr = 8'h01; tick();
        ToF_dr = 8'h05; tick();
        ToF_dr = 8'h01; tick();
        ToF_dr = 8'h05; tick();
        ToF_dr = 8'h00;
        repeat (20) tick();
        chk("ovr_flag", overrun, 8'h04);
        chk("ovr_ch2_acks", ack_cnt[2], 1);
        chk("ovr_ch0_acks", ack_cnt[0], 1);
        repeat (5) tick();
        chk("ovr_sticky", overrun, 8'h04);
        do_reset();
        chk("ovr_cleared", overrun, 0);

        // Reset on the first write cycle abandons the write.
        do_reset();
        clear_acks();
        ToF_dr = 8'h40;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (wea === 1'b1) got = 1;
        end
        chk("mid_wea_seen", got, 1);
        reset = 1'b1;
        tick();
        chk("mid_wea_dropped", wea, 0);
        chk("mid_no_ack", tof_ack, 0);
        tick();
        reset = 1'b0;
        got = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (wea === 1'b1) got = 1;
        end
        chk("mid_held_level_no_write", got, 0);
        chk("mid_ack_count", ack_cnt[6], 0);
        ToF_dr = 8'h00; tick();
        ToF_dr = 8'h40;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            if (tof_ack[6] === 1'b1) got = 1;
        end
        chk("mid_rewrite_ack", got, 1);
        chk("mid_rewrite_slot0", addra, 7'h60);
        ToF_dr = 8'h00;
        tick();

        // Randomized traffic with occasional resets, checked by the model each cycle.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            nd = ToF_dr;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    nd[i] = ~nd[i];
                    if (nd[i]) tof_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
            ToF_dr = nd;
            reset  = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset  = 1'b0;
        ToF_dr = '0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
